// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer-side request bus and FIFO write port shared by the round-robin arbiter
interface fifo_wr_arbiter_if #(
  parameter int width = 4,
  parameter int nreq  = 4
);
  logic [nreq-1:0]       req;
  logic [nreq*width-1:0] req_data;
  logic                  full;
  logic [nreq-1:0]       gnt;
  logic                  write;
  logic [width-1:0]      data_out;
  logic                  busy;
  modport master (output req, req_data, full, input gnt, write, data_out, busy);
  modport slave  (input req, req_data, full, output gnt, write, data_out, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter onto one FIFO write port; FIFO_ARB_CNT_EN adds wr_count
module fifo_wr_arbiter #(
  parameter int width = 4,
  parameter int nreq  = 4,
  parameter int burst = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef FIFO_ARB_CNT_EN
  output logic [15:0] wr_count,
`endif
  fifo_wr_arbiter_if.slave bus
);
  localparam int pw = nreq > 1 ? $clog2(nreq) : 1;
  localparam int cw = $clog2(burst + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [pw-1:0] ptr, gidx, pick_idx, cand;
  logic [cw-1:0] cnt;
  logic found, accept, release_c;
  assign accept = |(bus.gnt & bus.req) & ~bus.full;
  assign bus.write = accept;
  assign bus.busy = state == GRANT;
  assign bus.data_out = |bus.gnt ? bus.req_data[int'(gidx)*width +: width] : '0;
  // cyclic search for the first active request starting at ptr
  always_comb begin
    found = 1'b0;
    pick_idx = '0;
    cand = '0;
    for (int i = 0; i < nreq; i++) begin
      cand = pw'((int'(ptr) + i) % nreq);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick_idx = cand;
      end
    end
  end
  always_comb begin
    release_c = !bus.req[gidx] || (accept && cnt == cw'(burst - 1));
    state_d = state == IDLE ? (found ? GRANT : IDLE) : (release_c ? IDLE : GRANT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.gnt <= '0;
      gidx <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE && state_d == GRANT) begin
      bus.gnt <= nreq'(1) << pick_idx;
      gidx <= pick_idx;
      cnt <= '0;
    end else if (state == GRANT && state_d == IDLE) begin
      bus.gnt <= '0;
      ptr <= gidx == pw'(nreq - 1) ? '0 : gidx + 1'b1;
    end else if (accept) cnt <= cnt + 1'b1;
`ifdef FIFO_ARB_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) wr_count <= '0;
    else if (accept) wr_count <= wr_count + 1'b1;
`endif
endmodule
